// File: rtl/regularize_input.sv
// Front-panel input conditioner: edge detect, one-event arbitration, inactivity timer.
// Optional VM_INPUT_DEBOUNCE_EN inserts a per-bit debounce filter before edge detect.
module regularize_input #(
    parameter int NUM_ITEMS  = 4,
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 31,
    parameter int WAIT_TIME  = 100,
    parameter int COIN_VAL0  = 100,
    parameter int COIN_VAL1  = 500,
    parameter int COIN_VAL2  = 1000,
`ifdef VM_INPUT_DEBOUNCE_EN
    parameter int DEBOUNCE_CYCLES = 4,
`endif
    localparam int WAIT_BITS = $clog2(WAIT_TIME + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    input  logic [NUM_ITEMS-1:0]  i_available_item,
    input  logic [TOTAL_BITS-1:0] i_current_total,
    output logic [NUM_COINS-1:0]  o_coin_evt,
    output logic [NUM_ITEMS-1:0]  o_select_evt,
    output logic [TOTAL_BITS-1:0] o_input_total,
    output logic                  o_return_changes,
    output logic [WAIT_BITS-1:0]  o_wait_time
);

    localparam int NB = NUM_COINS + NUM_ITEMS + 1;
    localparam logic [WAIT_BITS-1:0] WAIT_LOAD = WAIT_BITS'(WAIT_TIME);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RETURN
    } state_t;

    state_t state, state_n;

    logic [NB-1:0] raw, s1, s2, filt, rise;
    logic [NUM_COINS-1:0] coin_rise, coin_oh, coin_n;
    logic [NUM_ITEMS-1:0] sel_rise, sel_oh, sel_n;
    logic [TOTAL_BITS-1:0] coin_val, total_n;
    logic [WAIT_BITS-1:0] wait_n;
    logic coin_hit, sel_hit, ret_rise;

    function automatic logic [TOTAL_BITS-1:0] coin_value(input int idx);
        case (idx)
            0:       return TOTAL_BITS'(COIN_VAL0);
            1:       return TOTAL_BITS'(COIN_VAL1);
            2:       return TOTAL_BITS'(COIN_VAL2);
            default: return '0;
        endcase
    endfunction

    assign raw = {i_trigger_return, i_select_item, i_input_coin};

    // History loads all-ones so a level held across reset release is not an edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= raw;
            s2 <= filt;
        end
    end

`ifdef VM_INPUT_DEBOUNCE_EN
    localparam int CB = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CB-1:0] cnt [NB];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt <= '1;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (s1[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CB'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i] <= s1[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign filt = s1;
`endif

    assign rise      = filt & ~s2;
    assign coin_rise = rise[NUM_COINS-1:0];
    assign sel_rise  = rise[NUM_COINS+NUM_ITEMS-1:NUM_COINS] & i_available_item;
    assign ret_rise  = rise[NB-1];
    assign coin_hit  = |coin_rise;
    assign sel_hit   = |sel_rise;

    // Lowest index wins: scan downwards so the last hit is the lowest
    always_comb begin
        coin_oh  = '0;
        coin_val = '0;
        sel_oh   = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (coin_rise[i]) begin
                coin_oh    = '0;
                coin_oh[i] = 1'b1;
                coin_val   = coin_value(i);
            end
        end
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (sel_rise[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        wait_n  = o_wait_time;
        coin_n  = '0;
        sel_n   = '0;
        total_n = '0;
        unique case (state)
            ST_IDLE: begin
                wait_n = '0;
                if (coin_hit && !ret_rise) begin
                    coin_n  = coin_oh;
                    total_n = coin_val;
                    wait_n  = WAIT_LOAD;
                    state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (ret_rise) begin
                    state_n = ST_RETURN;
                    wait_n  = '0;
                end else if (coin_hit) begin
                    coin_n  = coin_oh;
                    total_n = coin_val;
                    wait_n  = WAIT_LOAD;
                end else if (sel_hit) begin
                    sel_n  = sel_oh;
                    wait_n = WAIT_LOAD;
                end else if (o_wait_time == WAIT_BITS'(1)) begin
                    state_n = ST_RETURN;
                    wait_n  = '0;
                end else if (o_wait_time != '0) begin
                    wait_n = o_wait_time - 1'b1;
                end
            end
            ST_RETURN: begin
                wait_n = '0;
                if (i_current_total == '0) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                wait_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            o_coin_evt       <= '0;
            o_select_evt     <= '0;
            o_input_total    <= '0;
            o_return_changes <= 1'b0;
            o_wait_time      <= '0;
        end else begin
            state            <= state_n;
            o_coin_evt       <= coin_n;
            o_select_evt     <= sel_n;
            o_input_total    <= total_n;
            o_return_changes <= (state_n == ST_RETURN);
            o_wait_time      <= wait_n;
        end
    end

endmodule

// File: tb/tb_regularize_input.sv
// Scoreboard bench for regularize_input: directed presses, queued expectations.
// Latencies follow VM_INPUT_DEBOUNCE_EN when the bench is built with it.
module tb_regularize_input;

`ifdef VM_INPUT_DEBOUNCE_EN
    localparam int LAT  = 6;
    localparam int HOLD = 6;
`else
    localparam int LAT  = 2;
    localparam int HOLD = 1;
`endif
    localparam int GAP = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  i_input_coin;
    logic [3:0]  i_select_item;
    logic        i_trigger_return;
    logic [3:0]  i_available_item;
    logic [30:0] i_current_total;
    logic [2:0]  o_coin_evt;
    logic [3:0]  o_select_evt;
    logic [30:0] o_input_total;
    logic        o_return_changes;
    logic [6:0]  o_wait_time;

    regularize_input dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .i_available_item (i_available_item),
        .i_current_total  (i_current_total),
        .o_coin_evt       (o_coin_evt),
        .o_select_evt     (o_select_evt),
        .o_input_total    (o_input_total),
        .o_return_changes (o_return_changes),
        .o_wait_time      (o_wait_time)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          at;
        logic [2:0]  ce;
        logic [3:0]  se;
        logic [30:0] tot;
        logic        ret;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_ret = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic exp_pulse(input int at, input logic [2:0] ce,
                             input logic [3:0] se, input logic [30:0] tot);
        exp_t e;
        e.kind = 0; e.at = at; e.ce = ce; e.se = se; e.tot = tot; e.ret = 1'b0;
        sb.push_back(e);
    endtask

    task automatic exp_ret(input int at, input logic v);
        exp_t e;
        e.kind = 1; e.at = at; e.ce = '0; e.se = '0; e.tot = '0; e.ret = v;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_evt", sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        chk("evt_kind", kind, e.kind);
        chk("evt_cycle", cyc, e.at);
        if (kind == 0) begin
            chk("coin_evt", o_coin_evt, e.ce);
            chk("select_evt", o_select_evt, e.se);
            chk("input_total", o_input_total, e.tot);
        end else begin
            chk("return_changes", o_return_changes, e.ret);
        end
    endtask

    always @(negedge clk) begin
        if ((|o_coin_evt) || (|o_select_evt)) check_evt(0);
        if (o_return_changes !== prev_ret) check_evt(1);
        prev_ret = o_return_changes;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    int c, p;

    initial begin
        reset_n = 1'b0;
        i_input_coin = '0;
        i_select_item = '0;
        i_trigger_return = 1'b0;
        i_available_item = '0;
        i_current_total = 31'd700;
        tick(3);
        chk("rst_coin_evt", o_coin_evt, 0);
        chk("rst_select_evt", o_select_evt, 0);
        chk("rst_input_total", o_input_total, 0);
        chk("rst_return", o_return_changes, 0);
        chk("rst_wait", o_wait_time, 0);
        reset_n = 1'b1;
        tick(GAP);

        // single coin[1] press from IDLE
        c = cyc;
        i_input_coin = 3'b010;
        exp_pulse(c + LAT, 3'b010, 4'b0000, 31'd500);
        tick(HOLD);
        i_input_coin = '0;
        tick(c + LAT - cyc);
        chk("t1_wait_load", o_wait_time, 100);
        tick(1);
        chk("t1_wait_dec", o_wait_time, 99);
        tick(GAP);

        // held coin gives one pulse
        i_input_coin = 3'b001;
        exp_pulse(cyc + LAT, 3'b001, 4'b0000, 31'd100);
        tick(10);
        i_input_coin = '0;
        tick(GAP);

        // coin beats select; return beats coin
        i_available_item = 4'b0100;
        i_input_coin = 3'b001;
        i_select_item = 4'b0100;
        exp_pulse(cyc + LAT, 3'b001, 4'b0000, 31'd100);
        tick(HOLD);
        i_input_coin = '0;
        i_select_item = '0;
        tick(GAP);
        c = cyc;
        i_trigger_return = 1'b1;
        i_input_coin = 3'b100;
        exp_ret(c + LAT, 1'b1);
        tick(HOLD);
        i_trigger_return = 1'b0;
        i_input_coin = '0;
        tick(c + LAT - cyc);
        chk("t3_wait_return", o_wait_time, 0);
        i_current_total = '0;
        exp_ret(cyc + 1, 1'b0);
        tick(1);
        i_current_total = 31'd700;
        tick(GAP);

        // unavailable select ignored, available select reloads
        i_input_coin = 3'b100;
        exp_pulse(cyc + LAT, 3'b100, 4'b0000, 31'd1000);
        p = cyc + LAT;
        tick(HOLD);
        i_input_coin = '0;
        tick(GAP);
        i_available_item = 4'b0000;
        i_select_item = 4'b0010;
        tick(HOLD);
        i_select_item = '0;
        tick(GAP);
        chk("t4_wait_counting", o_wait_time, 100 - (cyc - p));
        c = cyc;
        i_available_item = 4'b0010;
        i_select_item = 4'b0010;
        exp_pulse(c + LAT, 3'b000, 4'b0010, 31'd0);
        tick(HOLD);
        i_select_item = '0;
        tick(c + LAT - cyc);
        p = cyc;
        chk("t4_wait_reload", o_wait_time, 100);

        // inactivity timeout, coins ignored while returning
        exp_ret(p + 100, 1'b1);
        tick(99);
        chk("t5_wait_last", o_wait_time, 1);
        tick(1);
        chk("t5_wait_zero", o_wait_time, 0);
        i_input_coin = 3'b001;
        tick(HOLD);
        i_input_coin = '0;
        tick(GAP);
        chk("t5_still_return", o_return_changes, 1);
        i_current_total = '0;
        exp_ret(cyc + 1, 1'b0);
        tick(1);
        i_current_total = 31'd700;
        chk("t5_idle_wait", o_wait_time, 0);
        i_select_item = 4'b0010;
        tick(HOLD);
        i_select_item = '0;
        tick(GAP);
        chk("t5_idle_wait2", o_wait_time, 0);

        // coin held through reset release gives nothing
        i_input_coin = 3'b001;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(GAP);
        i_input_coin = '0;
        tick(GAP);

        // reset mid-transaction aborts timer and pending pulse
        i_input_coin = 3'b010;
        exp_pulse(cyc + LAT, 3'b010, 4'b0000, 31'd500);
        tick(HOLD);
        i_input_coin = '0;
        tick(GAP);
        chk("t6_active_wait", o_wait_time != 0, 1);
        i_input_coin = 3'b001;
        tick(1);
        reset_n = 1'b0;
        tick(1);
        i_input_coin = '0;
        chk("t6_abort_wait", o_wait_time, 0);
        chk("t6_abort_coin", o_coin_evt, 0);
        reset_n = 1'b1;
        tick(GAP);
        tick(GAP);

`ifdef VM_INPUT_DEBOUNCE_EN
        i_input_coin = 3'b100;
        tick(2);
        i_input_coin = '0;
        tick(GAP);
        c = cyc;
        i_input_coin = 3'b100;
        exp_pulse(c + 6, 3'b100, 4'b0000, 31'd1000);
        tick(6);
        i_input_coin = '0;
        tick(GAP);
`endif

        chk("queue_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
